// File: rtl/pa_wb_pkg.sv
// Shared writeback types and sizing for the writeback FIFO and register file.
// Both ends of the FIFO use the wb_t bundle.
package pa_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 16;
    localparam int STATUS_W   = 2;
    localparam int NUM_REGS   = 32;
    localparam int PEND_W     = 2;
    localparam int RD_PORTS   = 4;

    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [STATUS_W-1:0]   status;
    } wb_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register outstanding-producer counters for RAW hazard detection.
// It also holds the reservation ready logic and the sticky orphan-writeback flag.
module wb_scoreboard
    import pa_wb_pkg::*;
#(
    parameter int NUM_REGS = pa_wb_pkg::NUM_REGS,
    parameter int PEND_W   = pa_wb_pkg::PEND_W
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  wb_t                   wbA_i,
    input  wb_t                   wbB_i,
    input  logic                  reserveA_i,
    input  logic                  reserveB_i,
    input  logic [REG_ADDR_W-1:0] reserveAddrA_i,
    input  logic [REG_ADDR_W-1:0] reserveAddrB_i,
    output logic                  reserveReadyA_o,
    output logic                  reserveReadyB_o,
    input  logic [REG_ADDR_W-1:0] readAddr_i [RD_PORTS],
    output logic                  readPending_o [RD_PORTS],
    output logic                  error_o
);

    localparam logic [PEND_W:0] CNT_MAX = (PEND_W+1)'((1 << PEND_W) - 1);

    logic [PEND_W-1:0] cnt_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_d [NUM_REGS];
    logic              error_q, error_d;
    logic              accA, accB, sameRes;
    logic [PEND_W:0]   cntB;

    // Ready deliberately ignores same-cycle writeback decrements.
    assign reserveReadyA_o = {1'b0, cnt_q[reserveAddrA_i]} < CNT_MAX;
    assign sameRes = reserveA_i && reserveReadyA_o
                  && (reserveAddrA_i == reserveAddrB_i);
    assign cntB = {1'b0, cnt_q[reserveAddrB_i]} + (PEND_W+1)'(sameRes);
    assign reserveReadyB_o = cntB < CNT_MAX;
    assign accA = reserveA_i && reserveReadyA_o;
    assign accB = reserveB_i && reserveReadyB_o;
    assign error_o = error_q;

    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            logic [PEND_W:0] hits;
            hits = (PEND_W+1)'(wbA_i.en && wbA_i.addr == readAddr_i[p])
                 + (PEND_W+1)'(wbB_i.en && wbB_i.addr == readAddr_i[p]);
            readPending_o[p] = {1'b0, cnt_q[readAddr_i[p]]} > hits;
        end
    end

    always_comb begin
        error_d = error_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [PEND_W:0] res, wbs, cur, dec;
            res = (PEND_W+1)'(accA && reserveAddrA_i == REG_ADDR_W'(r))
                + (PEND_W+1)'(accB && reserveAddrB_i == REG_ADDR_W'(r));
            wbs = (PEND_W+1)'(wbA_i.en && wbA_i.addr == REG_ADDR_W'(r))
                + (PEND_W+1)'(wbB_i.en && wbB_i.addr == REG_ADDR_W'(r));
            cur = {1'b0, cnt_q[r]};
            // Orphan writebacks are dropped from the count, never wrap it.
            dec = (wbs > cur) ? cur : wbs;
            if (wbs > cur) error_d = 1'b1;
            cnt_d[r] = PEND_W'(cur - dec + res);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Architectural register file with dual writeback, bypassed reads and status.
// Producer tracking is delegated to wb_scoreboard.
module writeback_regfile
    import pa_wb_pkg::*;
#(
    parameter int NUM_REGS = pa_wb_pkg::NUM_REGS,
    parameter int DATA_W   = pa_wb_pkg::DATA_W,
    parameter int PEND_W   = pa_wb_pkg::PEND_W
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enableA_i,
    input  logic                  enableB_i,
    input  logic [REG_ADDR_W-1:0] AddressA_i,
    input  logic [REG_ADDR_W-1:0] AddressB_i,
    input  logic [DATA_W-1:0]     DataA_i,
    input  logic [DATA_W-1:0]     DataB_i,
    input  logic [STATUS_W-1:0]   statusA_i,
    input  logic [STATUS_W-1:0]   statusB_i,
    input  logic                  reserveA_i,
    input  logic                  reserveB_i,
    input  logic [REG_ADDR_W-1:0] reserveAddrA_i,
    input  logic [REG_ADDR_W-1:0] reserveAddrB_i,
    output logic                  reserveReadyA_o,
    output logic                  reserveReadyB_o,
    input  logic [REG_ADDR_W-1:0] readAddr0_i,
    input  logic [REG_ADDR_W-1:0] readAddr1_i,
    input  logic [REG_ADDR_W-1:0] readAddr2_i,
    input  logic [REG_ADDR_W-1:0] readAddr3_i,
    output logic [DATA_W-1:0]     readData0_o,
    output logic [DATA_W-1:0]     readData1_o,
    output logic [DATA_W-1:0]     readData2_o,
    output logic [DATA_W-1:0]     readData3_o,
    output logic                  readPending0_o,
    output logic                  readPending1_o,
    output logic                  readPending2_o,
    output logic                  readPending3_o,
    output logic [STATUS_W-1:0]   status_o,
    output logic                  error_o
);

    wb_t                   wbA, wbB;
    logic [REG_ADDR_W-1:0] rdAddr [RD_PORTS];
    logic [DATA_W-1:0]     rdData [RD_PORTS];
    logic                  rdPend [RD_PORTS];
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [STATUS_W-1:0]   status_q, status_d;

    assign wbA = '{en: enableA_i, addr: AddressA_i,
                   data: DataA_i, status: statusA_i};
    assign wbB = '{en: enableB_i, addr: AddressB_i,
                   data: DataB_i, status: statusB_i};

    assign rdAddr[0] = readAddr0_i;
    assign rdAddr[1] = readAddr1_i;
    assign rdAddr[2] = readAddr2_i;
    assign rdAddr[3] = readAddr3_i;
    assign readData0_o = rdData[0];
    assign readData1_o = rdData[1];
    assign readData2_o = rdData[2];
    assign readData3_o = rdData[3];
    assign readPending0_o = rdPend[0];
    assign readPending1_o = rdPend[1];
    assign readPending2_o = rdPend[2];
    assign readPending3_o = rdPend[3];
    assign status_o = status_q;

    // B is the younger FIFO entry, so it wins both bypass and write.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            if (wbB.en && wbB.addr == rdAddr[p])      rdData[p] = wbB.data;
            else if (wbA.en && wbA.addr == rdAddr[p]) rdData[p] = wbA.data;
            else                                      rdData[p] = regs_q[rdAddr[p]];
        end
    end

    always_comb begin
        regs_d   = regs_q;
        status_d = status_q;
        if (wbA.en) begin
            regs_d[wbA.addr] = wbA.data;
            status_d         = wbA.status;
        end
        if (wbB.en) begin
            regs_d[wbB.addr] = wbB.data;
            status_d         = wbB.status;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            status_q <= '0;
        end else begin
            regs_q   <= regs_d;
            status_q <= status_d;
        end
    end

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .wbA_i           (wbA),
        .wbB_i           (wbB),
        .reserveA_i      (reserveA_i),
        .reserveB_i      (reserveB_i),
        .reserveAddrA_i  (reserveAddrA_i),
        .reserveAddrB_i  (reserveAddrB_i),
        .reserveReadyA_o (reserveReadyA_o),
        .reserveReadyB_o (reserveReadyB_o),
        .readAddr_i      (rdAddr),
        .readPending_o   (rdPend),
        .error_o         (error_o)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized bench for writeback_regfile.
// Expected values come from a counter/array model of the register file rules.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        enA, enB;
    logic [4:0]  adA, adB;
    logic [15:0] dA, dB;
    logic [1:0]  stA, stB;
    logic        rsA, rsB;
    logic [4:0]  raA, raB;
    logic        rdyA, rdyB;
    logic [4:0]  ra [4];
    logic [15:0] rd [4];
    logic        rp [4];
    logic [1:0]  st;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] m_reg [32];
    int          m_cnt [32];
    logic [1:0]  m_status;
    logic        m_err;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clock_i(clk), .reset_i(rst),
        .enableA_i(enA), .enableB_i(enB),
        .AddressA_i(adA), .AddressB_i(adB),
        .DataA_i(dA), .DataB_i(dB),
        .statusA_i(stA), .statusB_i(stB),
        .reserveA_i(rsA), .reserveB_i(rsB),
        .reserveAddrA_i(raA), .reserveAddrB_i(raB),
        .reserveReadyA_o(rdyA), .reserveReadyB_o(rdyB),
        .readAddr0_i(ra[0]), .readAddr1_i(ra[1]),
        .readAddr2_i(ra[2]), .readAddr3_i(ra[3]),
        .readData0_o(rd[0]), .readData1_o(rd[1]),
        .readData2_o(rd[2]), .readData3_o(rd[3]),
        .readPending0_o(rp[0]), .readPending1_o(rp[1]),
        .readPending2_o(rp[2]), .readPending3_o(rp[3]),
        .status_o(st), .error_o(err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int hits(logic [4:0] a);
        return ((enA && adA == a) ? 1 : 0) + ((enB && adB == a) ? 1 : 0);
    endfunction

    function automatic logic exp_rdyA();
        return m_cnt[raA] < 3;
    endfunction

    function automatic logic exp_rdyB();
        int extra;
        extra = (rsA && exp_rdyA() && raA == raB) ? 1 : 0;
        return (m_cnt[raB] + extra) < 3;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_status = '0;
        m_err    = 1'b0;
    endtask

    task automatic check_model(string tag);
        logic [15:0] ed;
        int          left;
        for (int p = 0; p < 4; p++) begin
            if (enB && adB == ra[p])      ed = dB;
            else if (enA && adA == ra[p]) ed = dA;
            else                          ed = m_reg[ra[p]];
            left = m_cnt[ra[p]] - hits(ra[p]);
            chk($sformatf("%s data%0d", tag, p), rd[p], ed);
            chk($sformatf("%s pend%0d", tag, p),
                16'(rp[p]), 16'(left > 0));
        end
        chk({tag, " readyA"}, 16'(rdyA), 16'(exp_rdyA()));
        chk({tag, " readyB"}, 16'(rdyB), 16'(exp_rdyB()));
        chk({tag, " status"}, 16'(st), 16'(m_status));
        chk({tag, " error"}, 16'(err), 16'(m_err));
    endtask

    task automatic model_update();
        int  res [32];
        int  h;
        logic a_ok, b_ok;
        a_ok = exp_rdyA();
        b_ok = exp_rdyB();
        for (int r = 0; r < 32; r++) res[r] = 0;
        if (rsA && a_ok) res[raA]++;
        if (rsB && b_ok) res[raB]++;
        for (int r = 0; r < 32; r++) begin
            h = hits(5'(r));
            if (h > m_cnt[r]) begin
                m_err    = 1'b1;
                m_cnt[r] = 0;
            end else begin
                m_cnt[r] = m_cnt[r] - h;
            end
            m_cnt[r] = m_cnt[r] + res[r];
        end
        if (enA) m_reg[adA] = dA;
        if (enB) m_reg[adB] = dB;
        if (enB)      m_status = stB;
        else if (enA) m_status = stA;
    endtask

    task automatic idle();
        enA = 0; enB = 0; adA = 0; adB = 0;
        dA = 0; dB = 0; stA = 0; stB = 0;
        rsA = 0; rsB = 0; raA = 0; raB = 0;
    endtask

    task automatic step(string tag);
        #1 check_model(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int p = 0; p < 4; p++) ra[p] = 5'd5;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        #1;
        chk("reset data0", rd[0], 16'h0000);
        chk("reset data3", rd[3], 16'h0000);
        chk("reset pend0", 16'(rp[0]), 16'h0);
        chk("reset readyA", 16'(rdyA), 16'h1);
        chk("reset readyB", 16'(rdyB), 16'h1);
        chk("reset status", 16'(st), 16'h0);
        chk("reset error", 16'(err), 16'h0);
        step("reset");

        enA = 1; adA = 5'd3; dA = 16'h1234; stA = 2'b01;
        enB = 1; adB = 5'd3; dB = 16'hBEEF; stB = 2'b10;
        ra[0] = 5'd3;
        #1 chk("bypass b wins", rd[0], 16'hBEEF);
        step("dual wb");
        idle();
        #1 chk("stored b wins", rd[0], 16'hBEEF);
        chk("status b", 16'(st), 16'h2);
        step("after dual wb");

        rsA = 1; raA = 5'd7; ra[0] = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1 chk("res7 readyA", 16'(rdyA), 16'h1);
            step("res7");
        end
        #1 chk("res7 full readyA", 16'(rdyA), 16'h0);
        chk("res7 pend", 16'(rp[0]), 16'h1);
        step("res7 4th ignored");
        idle();
        for (int i = 0; i < 3; i++) begin
            enA = 1; adA = 5'd7; dA = 16'(16'h0700 + i);
            #1 chk($sformatf("wb7 pend %0d", i), 16'(rp[0]),
                   16'(i < 2 ? 1 : 0));
            step("wb7");
        end
        idle();
        #1 chk("wb7 drained", 16'(rp[0]), 16'h0);
        chk("wb7 data", rd[0], 16'h0702);
        step("wb7 idle");

        rsA = 1; raA = 5'd9; rsB = 1; raB = 5'd9;
        #1 chk("res9 first readyB", 16'(rdyB), 16'h1);
        step("res9 pair");
        #1 chk("res9 readyA", 16'(rdyA), 16'h1);
        chk("res9 readyB", 16'(rdyB), 16'h0);
        step("res9 second pair");
        idle();
        raA = 5'd9; ra[1] = 5'd9;
        #1 chk("res9 full", 16'(rdyA), 16'h0);
        chk("res9 pend", 16'(rp[1]), 16'h1);
        step("res9 check");

        do_reset();
        idle();
        enA = 1; adA = 5'd12; dA = 16'h5A5A; ra[2] = 5'd12;
        #1 chk("r12 bypass", rd[2], 16'h5A5A);
        chk("r12 error pre", 16'(err), 16'h0);
        step("r12 orphan");
        idle();
        #1 chk("r12 error", 16'(err), 16'h1);
        chk("r12 pend", 16'(rp[2]), 16'h0);
        chk("r12 data", rd[2], 16'h5A5A);
        step("r12 a");
        step("r12 b");
        #1 chk("r12 sticky", 16'(err), 16'h1);
        step("r12 c");

        rsA = 1; raA = 5'd4; rsB = 1; raB = 5'd4;
        step("res4 pair");
        rsB = 0;
        step("res4 third");
        idle();
        enA = 1; adA = 5'd4; dA = 16'hAAAA;
        step("wb4");
        idle();
        ra[0] = 5'd4;
        #1 chk("r4 stored", rd[0], 16'hAAAA);
        chk("r4 pend", 16'(rp[0]), 16'h1);
        #1 rst = 1'b1;
        #1 chk("async rst data", rd[0], 16'h0000);
        chk("async rst pend", 16'(rp[0]), 16'h0);
        chk("async rst error", 16'(err), 16'h0);
        chk("async rst status", 16'(st), 16'h0);
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step("post async rst");

        for (int i = 0; i < 400; i++) begin
            enA = 1'($urandom_range(0, 1));
            enB = 1'($urandom_range(0, 1));
            adA = 5'($urandom_range(0, 7));
            adB = 5'($urandom_range(0, 7));
            dA  = 16'($urandom);
            dB  = 16'($urandom);
            stA = 2'($urandom);
            stB = 2'($urandom);
            rsA = 1'($urandom_range(0, 3) != 0);
            rsB = 1'($urandom_range(0, 3) != 0);
            raA = 5'($urandom_range(0, 7));
            raB = 5'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++) ra[p] = 5'($urandom_range(0, 7));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
